// File: rtl/attn_pkg.sv
// Shared types and constants for the attention engine's byte-serial link.
// Used by both the transmit streamer and the engine-side receiver.
package attn_pkg;

  localparam int ATTN_DATA_W   = 8;
  localparam int ATTN_FEATURES = 4;
  localparam int ATTN_ROWS     = 4;

  // Transmit sequencing: q byte (FIRST), k byte (SECOND), dead cycle (GAP).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    GAP    = 2'd3
  } tx_state_t;

endpackage

// File: rtl/attn_pair_fifo.sv
// Small synchronous FIFO holding packed {q,k} pairs.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Push while full and pop while empty are ignored.
module attn_pair_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset discards all stored pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/attn_pair_streamer.sv
// Transmit end of the attention engine's byte-serial slave link.
// Buffers (q,k) pairs and sends each as q then k on tx_data, followed by one
// dead cycle, while tracking feature/row position for downstream framing.
// Optional feature: define ATTN_STREAMER_STALL_CNT_EN to add the 16-bit
// stall_cnt output (cycles spent in FIRST with tx_rdy low, saturating,
// cleared on frame_done).
//
// Handshakes:
//  host side  - a pair transfers on a clock edge where in_vld && in_rdy;
//               in_rdy is !full from registered FIFO state only.
//  engine side - the q byte transfers on an edge where tx_vld && tx_rdy and is
//               held stable until then; the k byte is presented for exactly
//               one cycle and always transfers (engine accepts on vld alone);
//               the following cycle has tx_vld=0 because the engine does not
//               latch during its compute cycle.
module attn_pair_streamer
  import attn_pkg::*;
#(
  parameter int DATA_W     = ATTN_DATA_W,
  parameter int FEATURES   = ATTN_FEATURES,
  parameter int ROWS       = ATTN_ROWS,
  parameter int PAIR_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_q,
  input  logic [DATA_W-1:0] in_k,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_vld,
  input  logic              tx_rdy,
  output logic              row_done,
  output logic              frame_done,
  output logic              busy
`ifdef ATTN_STREAMER_STALL_CNT_EN
  , output logic [15:0]     stall_cnt
`endif
);

  localparam int FW = $clog2(FEATURES);
  localparam int RW = $clog2(ROWS);

  tx_state_t           state;
  tx_state_t           state_nxt;
  logic                pop;
  logic [2*DATA_W-1:0] fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   pair_q;
  logic [DATA_W-1:0]   pair_k;
  logic [FW-1:0]       feat_cnt;
  logic [RW-1:0]       row_cnt;
  logic                feat_last;
  logic                row_last;

  attn_pair_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (PAIR_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_vld),
    .pop   (pop),
    .wdata ({in_q, in_k}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_rdy    = !fifo_full;
  assign busy      = !fifo_empty || (state != IDLE);
  assign feat_last = (feat_cnt == FW'(FEATURES-1));
  assign row_last  = (row_cnt == RW'(ROWS-1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, FIFO pop and byte-bus drive; bus reads zero when not valid.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_vld    = 1'b0;
    tx_data   = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = FIRST;
        end
      end
      FIRST: begin
        tx_vld  = 1'b1;
        tx_data = pair_q;
        if (tx_rdy) state_nxt = SECOND;
      end
      SECOND: begin
        tx_vld    = 1'b1;
        tx_data   = pair_k;
        state_nxt = GAP;
      end
      GAP: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = FIRST;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pair register loaded from the FIFO head on every pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_q <= '0;
      pair_k <= '0;
    end else if (pop) begin
      pair_q <= fifo_rdata[2*DATA_W-1:DATA_W];
      pair_k <= fifo_rdata[DATA_W-1:0];
    end
  end

  // Feature/row position advances as each k byte goes out; the done pulses
  // land in the following GAP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_cnt   <= '0;
      row_cnt    <= '0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      row_done   <= (state == SECOND) && feat_last;
      frame_done <= (state == SECOND) && feat_last && row_last;
      if (state == SECOND) begin
        if (feat_last) begin
          feat_cnt <= '0;
          row_cnt  <= row_last ? '0 : row_cnt + RW'(1);
        end else begin
          feat_cnt <= feat_cnt + FW'(1);
        end
      end
    end
  end

`ifdef ATTN_STREAMER_STALL_CNT_EN
  // Saturating count of cycles the engine held off the q byte in this frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (frame_done) begin
      stall_cnt <= '0;
    end else if ((state == FIRST) && !tx_rdy && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
